axi4_lite_apb_bridge: RTL and testbench



---
 rtl/axi4_lite_apb_bridge.sv | 179 +++++++++++++++++
 tb/tb_axi4_lite_apb_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_apb_bridge.sv
// AXI4-Lite responder that re-issues each read or write as one APB3 transfer.
// Buffered AW/W slots, round-robin read/write arbitration, and a wait-cycle timeout that forces SLVERR.
module axi4_lite_apb_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WRESP, S_RRESP} state_t;

  state_t                  state_reg, state_next;
  logic                    aw_full_reg, w_full_reg;
  logic [ADDR_WIDTH-1:0]   aw_addr_reg;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic                    last_write_reg;
  logic [CW-1:0]           count_reg;
  logic                    psel_reg, penable_reg, pwrite_reg;
  logic [ADDR_WIDTH-1:0]   paddr_reg;
  logic [DATA_WIDTH-1:0]   pwdata_reg;
  logic                    bvalid_reg, rvalid_reg;
  logic [1:0]              bresp_reg, rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    write_pending, grant_write, grant_read;
  logic                    b_done, timeout_hit;
  logic [CW-1:0]           count_inc;
  logic [1:0]              apb_resp;

  assign write_pending = aw_full_reg && w_full_reg;
  assign b_done        = (state_reg == S_WRESP) && BREADY;
  assign count_inc     = count_reg + CW'(1);
  assign timeout_hit   = !PREADY && (count_inc == CW'(TIMEOUT));
  assign apb_resp      = PSLVERR ? 2'b10 : 2'b00;

  // Under contention the channel that did not win last time is granted.
  always_comb begin
    grant_write = 1'b0;
    grant_read  = 1'b0;
    if (state_reg == S_IDLE) begin
      if (write_pending && ARVALID) begin
        grant_write = !last_write_reg;
        grant_read  = last_write_reg;
      end else begin
        grant_write = write_pending;
        grant_read  = ARVALID;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (grant_write || grant_read) state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: if (PREADY || timeout_hit) state_next = pwrite_reg ? S_WRESP : S_RRESP;
      S_WRESP:  if (BREADY) state_next = S_IDLE;
      S_RRESP:  if (RREADY) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Write slots only drain once the B handshake closes the write.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
    end else if (b_done) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
    end else begin
      if (AWVALID && !aw_full_reg) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= AWADDR;
      end
      if (WVALID && !w_full_reg) begin
        w_full_reg <= 1'b1;
        w_data_reg <= WDATA;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg      <= S_IDLE;
      last_write_reg <= 1'b0;
      count_reg      <= '0;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      bvalid_reg     <= 1'b0;
      rvalid_reg     <= 1'b0;
      bresp_reg      <= 2'b00;
      rresp_reg      <= 2'b00;
      rdata_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      psel_reg    <= (state_next == S_SETUP) || (state_next == S_ACCESS);
      penable_reg <= (state_next == S_ACCESS);
      bvalid_reg  <= (state_next == S_WRESP);
      rvalid_reg  <= (state_next == S_RRESP);
      if (grant_write || grant_read) begin
        paddr_reg      <= grant_write ? aw_addr_reg : ARADDR;
        pwrite_reg     <= grant_write;
        pwdata_reg     <= w_data_reg;
        last_write_reg <= grant_write;
      end
      if (state_reg == S_SETUP) begin
        count_reg <= '0;
      end else if (state_reg == S_ACCESS && !PREADY) begin
        count_reg <= count_inc;
      end
      if (state_reg == S_ACCESS) begin
        if (PREADY) begin
          if (pwrite_reg) begin
            bresp_reg <= apb_resp;
          end else begin
            rresp_reg <= apb_resp;
            rdata_reg <= PRDATA;
          end
        end else if (timeout_hit) begin
          if (pwrite_reg) begin
            bresp_reg <= 2'b10;
          end else begin
            rresp_reg <= 2'b10;
            rdata_reg <= '0;
          end
        end
      end
    end
  end

  assign AWREADY = !aw_full_reg;
  assign WREADY  = !w_full_reg;
  assign ARREADY = grant_read;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign RVALID  = rvalid_reg;
  assign RRESP   = rresp_reg;
  assign RDATA   = rdata_reg;
  assign PSEL    = psel_reg;
  assign PENABLE = penable_reg;
  assign PWRITE  = pwrite_reg;
  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;

endmodule

// File: tb/tb_axi4_lite_apb_bridge.sv
// Bench for axi4_lite_apb_bridge: directed and random AXI transactions against an APB slave
// model, with a word-array scoreboard predicting read data, responses and cycle latencies.
module tb_axi4_lite_apb_bridge;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          ACLK, ARESETn;
  logic [AW-1:0] AWADDR, ARADDR, PADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA, PWDATA, PRDATA;
  logic [1:0]    BRESP, RRESP;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  axi4_lite_apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [DW-1:0] exp_mem   [16];
  logic [DW-1:0] slave_mem [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays the APB slave from the current falling edge (k=0) until the AXI response appears.
  task automatic run_xfer(input bit is_write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input bit err, input bit tmo, input int exp_psel_k);
    int psel_k = -1, pen_k = -1, valid_k = -1, acc = 0, exp_acc;
    bit unstable = 0;
    exp_acc = tmo ? TMO : waits + 1;
    for (int k = 0; k < 80; k++) begin
      if (is_write ? BVALID : RVALID) begin
        valid_k = k;
        break;
      end
      if (PSEL && psel_k < 0) psel_k = k;
      if (PSEL && (PADDR !== addr || PWRITE !== is_write || (is_write && PWDATA !== wdata))) unstable = 1;
      if (PSEL && PENABLE) begin
        if (pen_k < 0) pen_k = k;
        PREADY  = !tmo && (acc == waits);
        PSLVERR = PREADY && err;
        PRDATA  = slave_mem[PADDR];
        if (PREADY && PWRITE && !err) slave_mem[PADDR] = PWDATA;
        acc++;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      @(negedge ACLK);
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    check("psel_latency", 64'(psel_k), 64'(exp_psel_k));
    check("penable_latency", 64'(pen_k), 64'(exp_psel_k + 1));
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("resp_latency", 64'(valid_k), 64'(exp_psel_k + 1 + exp_acc));
    check("apb_addr_ctrl_data", 64'(unstable), 64'(0));
  endtask

  task automatic resp_phase(input bit is_write, input int hold, input logic [1:0] exp_resp,
                            input logic [DW-1:0] exp_rdata);
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        if (is_write) BREADY = 1'b1;
        else RREADY = 1'b1;
      end
      if (is_write) check("bresp", {BVALID, BRESP}, {1'b1, exp_resp});
      else check("rresp_rdata", {RVALID, RRESP, RDATA}, {1'b1, exp_resp, exp_rdata});
      @(negedge ACLK);
    end
    BREADY = 1'b0;
    RREADY = 1'b0;
    if (is_write) check("bvalid_drop", BVALID, 0);
    else check("rvalid_drop", RVALID, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int w_lead,
                          input int waits, input bit err, input bit tmo, input int hold);
    logic [1:0] exp_resp;
    exp_resp = (err || tmo) ? 2'b10 : 2'b00;
    if (w_lead > 0) begin
      WVALID = 1'b1;
      WDATA  = data;
      check("w_ready", WREADY, 1);
      @(negedge ACLK);
      WVALID = 1'b0;
      check("w_backpressure", WREADY, 0);
      for (int i = 1; i < w_lead; i++) @(negedge ACLK);
      check("no_psel_before_aw", PSEL, 0);
      AWVALID = 1'b1;
      AWADDR  = addr;
      check("aw_ready", AWREADY, 1);
    end else begin
      AWVALID = 1'b1;
      AWADDR  = addr;
      WVALID  = 1'b1;
      WDATA   = data;
      check("aw_w_ready", {AWREADY, WREADY}, 2'b11);
    end
    @(negedge ACLK);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("aw_backpressure", AWREADY, 0);
    run_xfer(1'b1, addr, data, waits, err, tmo, 1);
    resp_phase(1'b1, hold, exp_resp, '0);
    if (!err && !tmo) exp_mem[addr] = data;
    $display("write addr=%h data=%h lead=%0d waits=%0d err=%0d tmo=%0d resp=%b",
             addr, data, w_lead, waits, err, tmo, exp_resp);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int waits, input bit err, input bit tmo,
                         input int hold);
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_data;
    exp_resp = (err || tmo) ? 2'b10 : 2'b00;
    exp_data = tmo ? '0 : exp_mem[addr];
    ARVALID = 1'b1;
    ARADDR  = addr;
    #1;
    check("ar_ready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    run_xfer(1'b0, addr, '0, waits, err, tmo, 0);
    resp_phase(1'b0, hold, exp_resp, exp_data);
    $display("read  addr=%h data=%h waits=%0d err=%0d tmo=%0d resp=%b",
             addr, exp_data, waits, err, tmo, exp_resp);
  endtask

  initial begin
    logic [DW-1:0] d1, d3;
    ARESETn = 1'b0;
    {AWVALID, WVALID, BREADY, ARVALID, RREADY, PREADY, PSLVERR} = '0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; PRDATA = '0;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    @(negedge ACLK);
    @(negedge ACLK);
    check("reset_axi", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 9'b110000000);
    check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, RDATA}, '0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Basic write, read with waits and held RREADY, W-before-AW
    do_write(4'h4, 32'h2, 0, 0, 0, 0, 0);
    do_write(4'h8, 32'h3, 0, 1, 0, 0, 1);
    do_read(4'h8, 2, 0, 0, 3);
    do_write(4'hC, 32'h4, 2, 0, 0, 0, 0);
    do_read(4'h4, 0, 0, 0, 0);

    // Contention after a read: write wins, then the waiting read
    d1 = $urandom;
    AWVALID = 1'b1; AWADDR = 4'h5; WVALID = 1'b1; WDATA = d1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 4'h5;
    #1;
    check("arb1_read_blocked", ARREADY, 0);
    run_xfer(1'b1, 4'h5, d1, 0, 0, 0, 1);
    resp_phase(1'b1, 0, 2'b00, '0);
    exp_mem[5] = d1;
    $display("write addr=5 data=%h contention grant=write", d1);
    check("arb1_read_second", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    run_xfer(1'b0, 4'h5, '0, 0, 0, 0, 0);
    resp_phase(1'b0, 0, 2'b00, exp_mem[5]);
    $display("read  addr=5 data=%h contention second grant", exp_mem[5]);

    // Contention after a write: read wins and sees the old data
    do_write(4'h6, 32'hA5A5_0006, 0, 0, 0, 0, 0);
    d3 = $urandom;
    AWVALID = 1'b1; AWADDR = 4'h6; WVALID = 1'b1; WDATA = d3;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 4'h6;
    #1;
    check("arb2_read_wins", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    run_xfer(1'b0, 4'h6, '0, 0, 0, 0, 0);
    resp_phase(1'b0, 0, 2'b00, exp_mem[6]);
    $display("read  addr=6 data=%h contention grant=read", exp_mem[6]);
    run_xfer(1'b1, 4'h6, d3, 0, 0, 0, 1);
    resp_phase(1'b1, 0, 2'b00, '0);
    exp_mem[6] = d3;
    $display("write addr=6 data=%h contention second grant", d3);

    // Timeouts and slave errors
    do_write(4'h9, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
    do_read(4'h4, 0, 0, 1, 1);
    do_write(4'hA, 32'h1234_5678, 1, 1, 1, 0, 0);
    do_read(4'hC, 1, 1, 0, 0);

    // Reset during ACCESS
    AWVALID = 1'b1; AWADDR = 4'h3; WVALID = 1'b1; WDATA = 32'hCAFE_0003;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (PSEL && PENABLE) break;
      @(negedge ACLK);
    end
    check("rst_reached_access", {PSEL, PENABLE}, 2'b11);
    #2 ARESETn = 1'b0;
    #1;
    check("rst_async_apb", {PSEL, PENABLE}, 2'b00);
    check("rst_async_axi", {AWREADY, WREADY, BVALID, RVALID}, 4'b1100);
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst_no_response", {BVALID, RVALID, PSEL}, 3'b000);
    $display("reset during access, write to addr=3 discarded");
    do_write(4'h3, 32'h0000_0033, 0, 0, 0, 0, 0);
    do_read(4'h3, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 16; n++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 2));
      else
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
